// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: valid/ready host side, LSB-first serial line with
// optional parity and one or two stop bits.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | line high, ready for a word
//   S_START  | start bit (tx=0)
//   S_DATA   | data bits, LSB first, one per bit period
//   S_PARITY | parity bit (only reached when PARITY != 0)
//   S_STOP   | stop bit(s), tx=1, bit_count advances per stop bit
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1736,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 baud,
  output logic [3:0]           bit_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam int PAR_EN = (PARITY != 0) ? 1 : 0;
  localparam logic PAR_ODD = (PARITY == 2);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS + PAR_EN + STOP_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [3:0]           bit_cnt_q;
  logic                 accept;
  logic                 bit_end;

  assign accept    = valid && (state == S_IDLE);
  assign bit_end   = (state != S_IDLE) && (baud_cnt == CNT_MAX);
  assign ready     = (state == S_IDLE);
  assign busy      = ~ready;
  assign baud      = bit_end;
  assign bit_count = bit_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (bit_end && bit_cnt_q == LAST_DATA)
          state_nxt = (PAR_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx = parity_q;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end && bit_cnt_q == LAST_BIT) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift register and parity are loaded only on acceptance, so data may change freely mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
    end else begin
      if (accept) begin
        shift_q  <= data;
        parity_q <= (^data) ^ PAR_ODD;
      end else if (bit_end && state == S_DATA) begin
        shift_q <= shift_q >> 1;
      end

      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CNT_W'(1);

      if (state_nxt == S_IDLE) bit_cnt_q <= 4'd0;
      else if (bit_end)        bit_cnt_q <= bit_cnt_q + 4'd1;
    end
  end

endmodule
